scan_controller: RTL and testbench
==================================

SCAN_CONTROLLER -- requirements
Module: scan_controller

Interface
REQ-001 Parameter TICK_DIV, default 50000, clock cycles per digit slot; SHALL satisfy TICK_DIV >= BLANK_CYC+8.
REQ-002 Parameter BLANK_CYC, default 1000, dead-time cycles at start of each slot; SHALL be >= 1.
REQ-003 clk  in  1  system clock, all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 load_valid  in  1  new display frame offered.
REQ-006 load_ready  out  1  controller can accept a frame.
REQ-007 digits  in  16  four BCD nibbles; [15:12] = idx 3 (leftmost), [3:0] = idx 0 (rightmost).
REQ-008 dp_sel  in  4  decimal point per digit, bit i = idx i, 1 = lit.
REQ-009 lz_en  in  1  leading-zero suppression for this frame.
REQ-010 brightness  in  3  duty level 0..7.
REQ-011 digit_idx  out  2  slot currently scanned.
REQ-012 digit_bcd  out  4  nibble for current slot, raw pass-through (values >9 not altered).
REQ-013 dp_n  out  1  active-low decimal point for current slot.
REQ-014 an_n  out  4  active-low anode enables, one-hot-low or all high.
REQ-015 frame_done  out  1  one-cycle pulse at end of slot idx 3.

Function
REQ-016 Slot counter SHALL count 0..TICK_DIV-1 and wrap; on wrap digit_idx SHALL increment 0->1->2->3->0.
REQ-017 frame_done SHALL be 1 exactly in the cycle where digit_idx=3 and slot counter=TICK_DIV-1.
REQ-018 Per-slot FSM states BLANK, ON, OFF; BLANK for slot cycles 0..BLANK_CYC-1, then ON, then OFF until slot end; every slot re-enters BLANK.
REQ-019 L = (TICK_DIV-BLANK_CYC)/8 (integer); ON length SHALL be L*(brightness+1) cycles; remaining cycles OFF.
REQ-020 brightness SHALL be sampled once at slot cycle 0; changes mid-slot take effect next slot.
REQ-021 an_n SHALL be 1111 in BLANK and OFF; in ON, an_n[digit_idx]=0, others 1.
REQ-022 digit_bcd and dp_n SHALL reflect the active frame for digit_idx during the entire slot including BLANK.
REQ-023 Handshake: transfer when load_valid && load_ready; digits, dp_sel, lz_en captured into a pending register; load_ready SHALL drop the cycle after transfer.
REQ-024 At the frame_done cycle, a pending frame valid at the start of that cycle SHALL become the active frame for the next slot 0; pending clears and load_ready returns to 1 the following cycle.
REQ-025 A transfer in the frame_done cycle itself SHALL stay pending until the next frame_done (no same-cycle bypass).
REQ-026 Active frame SHALL never change except at a frame_done boundary (no tearing).
REQ-027 Leading-zero suppression: digit i (i>0) is suppressed iff active lz_en=1 and for all j>=i nibble j=0 and dp_sel[j]=0; digit 0 is never suppressed.
REQ-028 A suppressed digit SHALL hold an_n=1111 and dp_n=1 for its whole slot; digit_bcd still driven with 0.
REQ-029 load_valid held while load_ready=0 SHALL be ignored, not lost: upstream keeps it asserted.

Reset
REQ-030 rst low SHALL asynchronously force: slot counter 0, digit_idx 0, state BLANK, an_n 1111, dp_n 1, digit_bcd 0, frame_done 0, load_ready 1.
REQ-031 Reset SHALL set active frame to digits 0000, dp_sel 0000, lz_en 0, and discard any pending frame.
REQ-032 After rst release, scanning SHALL start at slot cycle 0 of digit_idx 0 on the first rising clk edge.

Verification (TICK_DIV=20, BLANK_CYC=4, so L=2)
REQ-033 Reset: rst low mid-slot -> an_n=1111, dp_n=1, load_ready=1, digit_idx=0 immediately, before any clk edge.
REQ-034 Load 0x1234, dp_sel=0100, brightness=7 -> after next frame_done, idx0 slot: an_n=1110 slot cycles 4..19, digit_bcd=4; idx2 dp_n=0, digit_bcd=2; idx3 digit_bcd=1.
REQ-035 brightness=0 -> per slot an_n active only cycles 4..5; brightness=3 -> cycles 4..11; change at slot cycle 7 -> applies from next slot.
REQ-036 lz_en=1, 0x0070 -> idx3, idx2 an_n=1111 whole slot; idx1 shows 7; 0x0000 -> only idx0 lit showing 0; 0x0070 with dp_sel[3]=1 -> no suppression.
REQ-037 Load A mid-frame, then B held valid -> load_ready low until after frame_done; A displayed full next frame; B accepted cycle after ready returns, displayed one frame later; B offered in frame_done cycle commits a frame later.
REQ-038 Reset with pending frame -> after release display shows 0000 on all four slots, pending frame never appears.

Source files
------------

// File: rtl/scan_controller.sv
// scan_controller: 4-digit multiplexed display scanner with per-slot blanking, PWM brightness,
// leading-zero suppression and a tear-free frame load handshake.
module scan_controller #(
    parameter int TICK_DIV  = 50000,
    parameter int BLANK_CYC = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_sel,
    input  logic        lz_en,
    input  logic [2:0]  brightness,
    output logic [1:0]  digit_idx,
    output logic [3:0]  digit_bcd,
    output logic        dp_n,
    output logic [3:0]  an_n,
    output logic        frame_done
);
    localparam int CW = $clog2(TICK_DIV);
    localparam int L  = (TICK_DIV - BLANK_CYC) / 8;
    typedef enum logic [1:0] {BLANK, ON, OFF} state_t;
    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [CW:0]   on_end;
    logic [2:0]    bright_q;
    logic [15:0]   act_digits, pend_digits;
    logic [3:0]    act_dp, pend_dp, zero, supp;
    logic          act_lz, pend_lz, pend_valid, slot_end;
    assign slot_end   = cnt == CW'(TICK_DIV - 1);
    assign cnt_nxt    = slot_end ? '0 : cnt + 1'b1;
    assign frame_done = slot_end && digit_idx == 2'd3;
    assign load_ready = !pend_valid;
    // one cycle wider than the counter: at full brightness the ON window can end exactly at TICK_DIV
    assign on_end     = (CW+1)'(BLANK_CYC + L) + (CW+1)'(L) * (CW+1)'(bright_q);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            digit_idx <= '0;
            bright_q  <= '0;
            state     <= BLANK;
        end else begin
            cnt   <= cnt_nxt;
            state <= state_nxt;
            if (slot_end) digit_idx <= digit_idx + 2'd1;
            if (cnt == '0) bright_q <= brightness;
        end
    end
    always_comb begin
        state_nxt = state;
        if (slot_end) state_nxt = BLANK;
        else if (state == BLANK && cnt_nxt == CW'(BLANK_CYC)) state_nxt = ON;
        else if (state == ON && {1'b0, cnt_nxt} == on_end) state_nxt = OFF;
    end
    // pending frame only moves to active on frame_done, so a slot never mixes two frames
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_digits  <= '0;
            act_dp      <= '0;
            act_lz      <= 1'b0;
            pend_digits <= '0;
            pend_dp     <= '0;
            pend_lz     <= 1'b0;
            pend_valid  <= 1'b0;
        end else if (frame_done && pend_valid) begin
            act_digits <= pend_digits;
            act_dp     <= pend_dp;
            act_lz     <= pend_lz;
            pend_valid <= 1'b0;
        end else if (load_valid && !pend_valid) begin
            pend_digits <= digits;
            pend_dp     <= dp_sel;
            pend_lz     <= lz_en;
            pend_valid  <= 1'b1;
        end
    end
    always_comb begin
        zero = '0;
        for (int i = 0; i < 4; i++) zero[i] = act_digits[i*4 +: 4] == 4'd0 && !act_dp[i];
    end
    assign supp[3]   = act_lz && zero[3];
    assign supp[2]   = supp[3] && zero[2];
    assign supp[1]   = supp[2] && zero[1];
    assign supp[0]   = 1'b0;
    assign digit_bcd = act_digits[{digit_idx, 2'b00} +: 4];
    assign dp_n      = supp[digit_idx] || !act_dp[digit_idx];
    assign an_n      = (state == ON && !supp[digit_idx]) ? ~(4'b0001 << digit_idx) : 4'hF;
endmodule

// File: tb/tb_scan_controller.sv
// tb_scan_controller: scoreboard bench for scan_controller with TICK_DIV=20, BLANK_CYC=4 (L=2).
module tb_scan_controller;
    localparam int TD = 20;
    typedef struct { int idx; int bcd; int dp_n; int first; int cnt; } exp_t;
    logic        clk = 0, rst = 0, load_valid = 0, lz_en = 0;
    logic [15:0] digits = '0;
    logic [3:0]  dp_sel = '0;
    logic [2:0]  brightness = 3'd7;
    logic        load_ready, dp_n, frame_done;
    logic [1:0]  digit_idx;
    logic [3:0]  digit_bcd, an_n;
    exp_t        exp_q[$];
    int          checks = 0, errors = 0, t = 0;
    bit          mon_en = 0;

    scan_controller #(.TICK_DIV(20), .BLANK_CYC(4)) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
        .digits(digits), .dp_sel(dp_sel), .lz_en(lz_en), .brightness(brightness),
        .digit_idx(digit_idx), .digit_bcd(digit_bcd), .dp_n(dp_n), .an_n(an_n),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic exp_t mk(int idx, logic [15:0] d, logic [3:0] dp, bit lz, int b);
        exp_t e;
        bit sup = lz && idx > 0;
        for (int j = idx; j < 4; j++) if (d[j*4 +: 4] != 4'd0 || dp[j]) sup = 0;
        e.idx   = idx;
        e.bcd   = int'(d[idx*4 +: 4]);
        e.dp_n  = (sup || !dp[idx]) ? 1 : 0;
        e.first = sup ? -1 : 4;
        e.cnt   = sup ? 0 : 2 * (b + 1);
        return e;
    endfunction

    task automatic push_slot(input int idx, input logic [15:0] d, input logic [3:0] dp, input bit lz, input int b);
        exp_q.push_back(mk(idx, d, dp, lz, b));
    endtask

    task automatic push_frame(input logic [15:0] d, input logic [3:0] dp, input bit lz, input int b);
        for (int i = 0; i < 4; i++) push_slot(i, d, dp, lz, b);
    endtask

    task automatic goto(input int target);
        while (t < target) begin
            @(negedge clk);
            t++;
        end
    endtask

    // slot monitor: summarises each observed slot and compares it against the scoreboard head
    initial begin
        int cyc, sn, o_idx, o_bcd, o_dp, o_first, o_cnt, o_fd;
        bit o_ok;
        exp_t e;
        cyc = 0; sn = 0; o_idx = 0; o_bcd = 0; o_dp = 0; o_first = -1; o_cnt = 0; o_fd = 0; o_ok = 1;
        forever begin
            @(negedge clk);
            if (!mon_en) cyc = 0;
            else begin
                if (cyc == 0) begin
                    o_idx = int'(digit_idx); o_bcd = int'(digit_bcd); o_dp = int'(dp_n);
                    o_first = -1; o_cnt = 0; o_fd = 0; o_ok = 1;
                end
                if (int'(digit_idx) != o_idx || int'(digit_bcd) != o_bcd || int'(dp_n) != o_dp) o_ok = 0;
                if (an_n != 4'hF) begin
                    if (o_first < 0) o_first = cyc;
                    if (cyc != o_first + o_cnt) o_ok = 0;
                    if (an_n != ~(4'b0001 << o_idx)) o_ok = 0;
                    o_cnt++;
                end
                if (frame_done) o_fd += (cyc == TD - 1) ? 1 : 100;
                if (cyc == TD - 1) begin
                    check($sformatf("s%0d.sb_nonempty", sn), int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check($sformatf("s%0d.idx", sn), o_idx, e.idx);
                        check($sformatf("s%0d.i%0d.bcd", sn, e.idx), o_bcd, e.bcd);
                        check($sformatf("s%0d.i%0d.dp_n", sn, e.idx), o_dp, e.dp_n);
                        check($sformatf("s%0d.i%0d.on_first", sn, e.idx), o_first, e.first);
                        check($sformatf("s%0d.i%0d.on_cnt", sn, e.idx), o_cnt, e.cnt);
                        check($sformatf("s%0d.i%0d.stable", sn, e.idx), int'(o_ok), 1);
                        check($sformatf("s%0d.i%0d.frame_done", sn, e.idx), o_fd, e.idx == 3 ? 1 : 0);
                    end
                    sn++;
                end
                cyc = (cyc == TD - 1) ? 0 : cyc + 1;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at t=%0d", t);
        $fatal(1, "watchdog");
    end

    initial begin
        push_frame(16'h0000, 4'b0000, 0, 7);
        repeat (3) @(posedge clk);
        #1 rst = 1; mon_en = 1;
        @(negedge clk); t = 0;
        check("ready_after_reset", load_ready, 1);
        goto(25);
        check("ready_idle", load_ready, 1);
        digits = 16'h1234; dp_sel = 4'b0100; lz_en = 0; load_valid = 1;
        push_frame(16'h1234, 4'b0100, 0, 7);
        goto(26);
        check("ready_drop", load_ready, 0);
        digits = 16'h5678; dp_sel = 4'b0001;
        push_frame(16'h5678, 4'b0001, 0, 7);
        goto(50);
        check("ready_held", load_ready, 0);
        goto(79);
        check("ready_at_fd", load_ready, 0);
        check("fd_pulse", frame_done, 1);
        goto(80);
        check("ready_back", load_ready, 1);
        goto(81);
        check("ready_b_taken", load_ready, 0);
        load_valid = 0;
        goto(160);
        check("ready_free", load_ready, 1);
        push_frame(16'h5678, 4'b0001, 0, 7);
        goto(239);
        check("ready_fd_cycle", load_ready, 1);
        digits = 16'h0070; dp_sel = 4'b0000; lz_en = 1; load_valid = 1;
        push_slot(0, 16'h0070, 4'b0000, 1, 7);
        for (int i = 1; i < 4; i++) push_slot(i, 16'h0070, 4'b0000, 1, 0);
        goto(240);
        check("ready_c_taken", load_ready, 0);
        load_valid = 0;
        goto(327);
        brightness = 3'd0;
        goto(330);
        check("ready_d", load_ready, 1);
        digits = 16'h0000; dp_sel = 4'b0000; lz_en = 1; load_valid = 1;
        for (int i = 0; i < 4; i++) push_slot(i, 16'h0000, 4'b0000, 1, i < 2 ? 0 : 3);
        goto(331);
        load_valid = 0;
        goto(427);
        brightness = 3'd3;
        goto(430);
        digits = 16'h0070; dp_sel = 4'b1000; lz_en = 1; load_valid = 1;
        push_frame(16'h0070, 4'b1000, 1, 3);
        push_slot(0, 16'h0070, 4'b1000, 1, 3);
        goto(431);
        load_valid = 0;
        goto(582);
        digits = 16'h9999; dp_sel = 4'b1111; lz_en = 0; load_valid = 1;
        goto(583);
        check("ready_f_pending", load_ready, 0);
        load_valid = 0;
        goto(585);
        check("pre_rst_an", an_n, 4'b1101);
        check("pre_rst_bcd", digit_bcd, 7);
        mon_en = 0;
        #2 rst = 0;
        #1;
        check("rst_an", an_n, 4'hF);
        check("rst_dp", dp_n, 1);
        check("rst_ready", load_ready, 1);
        check("rst_idx", digit_idx, 0);
        check("rst_bcd", digit_bcd, 0);
        check("rst_fd", frame_done, 0);
        push_frame(16'h0000, 4'b0000, 0, 3);
        push_frame(16'h0000, 4'b0000, 0, 3);
        repeat (3) @(posedge clk);
        #1 rst = 1; mon_en = 1;
        @(negedge clk); t = 0;
        check("ready_after_rst2", load_ready, 1);
        goto(160);
        check("sb_drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
